// File: rtl/qea_run_ctrl.sv
// Host-side job sequencer for one QEA run: load gate context, seed the state RAM with |0...0>,
// start the core, wait for completion under a timeout and stream the final state vector out.
module qea_run_ctrl #(
  parameter int PE_NUM_WIDTH            = 2,
  parameter int PE_NUM                  = 4,
  parameter int DATA_WIDTH              = 32,
  parameter int MAX_QBIT_WIDTH          = 6,
  parameter int STATE_DATA_WIDTH        = 2 * DATA_WIDTH,
  parameter int STATE_ADDR_WIDTH        = 16,
  parameter int GATE_CONTEXT_DATA_WIDTH = 2 * DATA_WIDTH,
  parameter int GATE_CONTEXT_ADDR_WIDTH = 16,
  parameter int NUM_FRAC_BIT            = 30,
  parameter int RD_LAT                  = 2,
  parameter int TO_WIDTH                = 32
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 i_run,
  input  logic                                 i_abort,
  input  logic [GATE_CONTEXT_ADDR_WIDTH-1:0]   i_ins_num,
  input  logic [MAX_QBIT_WIDTH-1:0]            i_qbit_num,
  input  logic [TO_WIDTH-1:0]                  i_timeout,
  input  logic                                 i_ctx_valid,
  input  logic [GATE_CONTEXT_DATA_WIDTH-1:0]   i_ctx_data,
  output logic                                 o_ctx_ready,
  output logic                                 o_qea_start,
  output logic [MAX_QBIT_WIDTH-1:0]            o_qea_qbit_num,
  output logic                                 o_qea_ctx_en,
  output logic                                 o_qea_ctx_wea,
  output logic [GATE_CONTEXT_ADDR_WIDTH-1:0]   o_qea_ctx_addr,
  output logic [GATE_CONTEXT_DATA_WIDTH-1:0]   o_qea_ctx_data,
  output logic                                 o_qea_state_ena,
  output logic                                 o_qea_state_wea,
  output logic [STATE_ADDR_WIDTH-1:0]          o_qea_state_addra,
  output logic [PE_NUM*STATE_DATA_WIDTH-1:0]   o_qea_state_dina,
  input  logic                                 i_qea_complete,
  input  logic [PE_NUM*STATE_DATA_WIDTH-1:0]   i_qea_state_dout,
  output logic                                 o_rd_valid,
  input  logic                                 i_rd_ready,
  output logic [STATE_ADDR_WIDTH-1:0]          o_rd_addr,
  output logic [PE_NUM*STATE_DATA_WIDTH-1:0]   o_rd_data,
  output logic                                 o_busy,
  output logic                                 o_done,
  output logic [1:0]                           o_err
);

  localparam int WordW = PE_NUM * STATE_DATA_WIDTH;
  localparam int WaitW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam logic [WaitW-1:0] WaitLast = WaitW'(RD_LAT - 1);
  localparam logic [MAX_QBIT_WIDTH-1:0] QbitMin = MAX_QBIT_WIDTH'(PE_NUM_WIDTH);
  localparam logic [MAX_QBIT_WIDTH-1:0] QbitMax = MAX_QBIT_WIDTH'(PE_NUM_WIDTH + STATE_ADDR_WIDTH);
  localparam logic [DATA_WIDTH-1:0] OneFx = DATA_WIDTH'(1) << NUM_FRAC_BIT;
  // |0...0>: amplitude 1.0 in the real field of the most-significant PE lane of word 0.
  localparam logic [WordW-1:0] InitWord = {OneFx, {(WordW - DATA_WIDTH){1'b0}}};

  localparam logic [1:0] ErrOk      = 2'd0;
  localparam logic [1:0] ErrQbit    = 2'd1;
  localparam logic [1:0] ErrTimeout = 2'd2;
  localparam logic [1:0] ErrAbort   = 2'd3;

  typedef enum logic [3:0] {
    StIdle, StLoadCtx, StInitSt, StStart, StRun, StRdAddr, StRdWait, StRdOut, StFin
  } state_e;

  state_e                              state_q;
  logic [GATE_CONTEXT_ADDR_WIDTH-1:0]  ins_q;
  logic [TO_WIDTH-1:0]                 timeout_q;
  logic [STATE_ADDR_WIDTH-1:0]         nwords_m1_q;
  logic [GATE_CONTEXT_ADDR_WIDTH-1:0]  ctx_idx_q;
  logic [STATE_ADDR_WIDTH-1:0]         word_idx_q;
  logic [TO_WIDTH-1:0]                 run_cnt_q;
  logic [WaitW-1:0]                    wait_cnt_q;

  logic                                qbit_legal;
  logic [MAX_QBIT_WIDTH-1:0]           qbit_shift;
  logic [STATE_ADDR_WIDTH:0]           nwords;
  logic [STATE_ADDR_WIDTH-1:0]         nwords_m1;
  logic [TO_WIDTH-1:0]                 run_cnt_inc;

  always_comb begin
    qbit_legal  = (i_qbit_num >= QbitMin) && (i_qbit_num <= QbitMax);
    qbit_shift  = i_qbit_num - QbitMin;
    nwords      = (STATE_ADDR_WIDTH + 1)'(1) << qbit_shift;
    nwords_m1   = STATE_ADDR_WIDTH'(nwords - (STATE_ADDR_WIDTH + 1)'(1));
    // RUN-cycle counter saturates instead of wrapping.
    run_cnt_inc = (run_cnt_q == '1) ? run_cnt_q : run_cnt_q + TO_WIDTH'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q           <= StIdle;
      ins_q             <= '0;
      timeout_q         <= '0;
      nwords_m1_q       <= '0;
      ctx_idx_q         <= '0;
      word_idx_q        <= '0;
      run_cnt_q         <= '0;
      wait_cnt_q        <= '0;
      o_ctx_ready       <= 1'b0;
      o_qea_start       <= 1'b0;
      o_qea_qbit_num    <= '0;
      o_qea_ctx_en      <= 1'b0;
      o_qea_ctx_wea     <= 1'b0;
      o_qea_ctx_addr    <= '0;
      o_qea_ctx_data    <= '0;
      o_qea_state_ena   <= 1'b0;
      o_qea_state_wea   <= 1'b0;
      o_qea_state_addra <= '0;
      o_qea_state_dina  <= '0;
      o_rd_valid        <= 1'b0;
      o_rd_addr         <= '0;
      o_rd_data         <= '0;
      o_busy            <= 1'b0;
      o_done            <= 1'b0;
      o_err             <= ErrOk;
    end else begin
      // Strobes are single-cycle unless a state re-asserts them.
      o_qea_start     <= 1'b0;
      o_done          <= 1'b0;
      o_qea_ctx_en    <= 1'b0;
      o_qea_ctx_wea   <= 1'b0;
      o_qea_state_ena <= 1'b0;
      o_qea_state_wea <= 1'b0;

      if (i_abort && (state_q != StIdle) && (state_q != StFin)) begin
        o_ctx_ready <= 1'b0;
        o_rd_valid  <= 1'b0;
        o_err       <= ErrAbort;
        o_done      <= 1'b1;
        state_q     <= StFin;
      end else begin
        case (state_q)
          StIdle: begin
            if (i_run) begin
              ins_q          <= i_ins_num;
              timeout_q      <= i_timeout;
              nwords_m1_q    <= nwords_m1;
              o_qea_qbit_num <= i_qbit_num;
              ctx_idx_q      <= '0;
              word_idx_q     <= '0;
              o_err          <= ErrOk;
              o_busy         <= 1'b1;
              if (!qbit_legal) begin
                o_err   <= ErrQbit;
                o_done  <= 1'b1;
                state_q <= StFin;
              end else if (i_ins_num == '0) begin
                state_q <= StInitSt;
              end else begin
                o_ctx_ready <= 1'b1;
                state_q     <= StLoadCtx;
              end
            end
          end

          StLoadCtx: begin
            if (i_ctx_valid && o_ctx_ready) begin
              o_qea_ctx_en   <= 1'b1;
              o_qea_ctx_wea  <= 1'b1;
              o_qea_ctx_addr <= ctx_idx_q;
              o_qea_ctx_data <= i_ctx_data;
              if (ctx_idx_q == ins_q - GATE_CONTEXT_ADDR_WIDTH'(1)) begin
                o_ctx_ready <= 1'b0;
                state_q     <= StInitSt;
              end else begin
                ctx_idx_q <= ctx_idx_q + GATE_CONTEXT_ADDR_WIDTH'(1);
              end
            end
          end

          StInitSt: begin
            o_qea_state_ena   <= 1'b1;
            o_qea_state_wea   <= 1'b1;
            o_qea_state_addra <= word_idx_q;
            o_qea_state_dina  <= (word_idx_q == '0) ? InitWord : '0;
            if (word_idx_q == nwords_m1_q) begin
              word_idx_q <= '0;
              state_q    <= StStart;
            end else begin
              word_idx_q <= word_idx_q + STATE_ADDR_WIDTH'(1);
            end
          end

          // The last state write is on the RAM port during this cycle; start follows it.
          StStart: begin
            o_qea_start <= 1'b1;
            run_cnt_q   <= '0;
            state_q     <= StRun;
          end

          StRun: begin
            run_cnt_q <= run_cnt_inc;
            // A complete level left over from a previous job is ignored on the first RUN cycle.
            if ((run_cnt_q != '0) && i_qea_complete) begin
              o_qea_state_ena   <= 1'b1;
              o_qea_state_addra <= '0;
              word_idx_q        <= '0;
              state_q           <= StRdAddr;
            end else if ((timeout_q != '0) && (run_cnt_inc == timeout_q)) begin
              o_err   <= ErrTimeout;
              o_done  <= 1'b1;
              state_q <= StFin;
            end
          end

          StRdAddr: begin
            wait_cnt_q <= '0;
            state_q    <= StRdWait;
          end

          StRdWait: begin
            if (wait_cnt_q == WaitLast) begin
              o_rd_data  <= i_qea_state_dout;
              o_rd_addr  <= word_idx_q;
              o_rd_valid <= 1'b1;
              state_q    <= StRdOut;
            end else begin
              wait_cnt_q <= wait_cnt_q + WaitW'(1);
            end
          end

          StRdOut: begin
            if (i_rd_ready) begin
              o_rd_valid <= 1'b0;
              if (word_idx_q == nwords_m1_q) begin
                o_done  <= 1'b1;
                state_q <= StFin;
              end else begin
                o_qea_state_ena   <= 1'b1;
                o_qea_state_addra <= word_idx_q + STATE_ADDR_WIDTH'(1);
                word_idx_q        <= word_idx_q + STATE_ADDR_WIDTH'(1);
                state_q           <= StRdAddr;
              end
            end
          end

          StFin: begin
            o_busy  <= 1'b0;
            state_q <= StIdle;
          end

          default: state_q <= StIdle;
        endcase
      end
    end
  end

endmodule
